// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (SYNC, CNT_LO, CNT_HI,
// 4*CNT little-endian data bytes, XOR checksum) and writes words to IMEM from address 0.
module imem_loader #(
    parameter int          ADDR_W    = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_hold,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_core_hold;
    logic                r_done;
    logic                r_err;
    logic [15:0]         r_cnt;
    logic [ADDR_W:0]     r_ptr;   // one extra bit so a full-capacity load never wraps
    logic [1:0]          r_bidx;
    logic [31:0]         r_word;
    logic [7:0]          r_xor;

    logic                w_acc;
    logic [15:0]         w_cnt;
    logic [ADDR_W:0]     w_ptr_inc;
    logic [31:0]         w_word;

    assign w_acc     = i_in_valid & r_in_ready;
    assign w_cnt     = {i_in_data, r_cnt[7:0]};
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_word    = {i_in_data, r_word[23:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_hold  <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_bidx       <= '0;
            r_word       <= '0;
            r_xor        <= '0;
        end else begin
            r_in_ready <= 1'b1;
            r_imem_we  <= 1'b0;
            if (w_acc) begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (i_in_data == SYNC_BYTE) begin
                            r_state     <= S_CNT_LO;
                            r_done      <= 1'b0;
                            r_err       <= 1'b0;
                            r_core_hold <= 1'b1;
                        end
                    end
                    S_CNT_LO: begin
                        r_cnt[7:0] <= i_in_data;
                        r_xor      <= i_in_data;
                        r_state    <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        r_cnt  <= w_cnt;
                        r_xor  <= r_xor ^ i_in_data;
                        r_ptr  <= '0;
                        r_bidx <= '0;
                        if ({1'b0, w_cnt} > CAP) begin
                            r_state     <= S_ERR;
                            r_err       <= 1'b1;
                            r_core_hold <= 1'b1;
                        end else if (w_cnt == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_xor                     <= r_xor ^ i_in_data;
                        r_word[{r_bidx, 3'b000} +: 8] <= i_in_data;
                        r_bidx                    <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_ptr[ADDR_W-1:0];
                            r_imem_wdata <= w_word;
                            r_ptr        <= w_ptr_inc;
                            if (16'(w_ptr_inc) == r_cnt)
                                r_state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (i_in_data == r_xor) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_core_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_core_hold  = r_core_hold;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized frames and gaps.
module tb_imem_loader;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          o_in_ready, o_imem_we, o_core_hold, o_done, o_err;
    logic [AW-1:0] o_imem_addr;
    logic [31:0]   o_imem_wdata;

    imem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(o_in_ready), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
        .o_imem_wdata(o_imem_wdata), .o_core_hold(o_core_hold), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [31:0] tb_mem [0:(1<<AW)-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes after SYNC are collected and their position in the
    // frame decides what they mean.
    bit            m_ready = 0, m_we = 0, m_hold = 1, m_done = 0, m_err = 0, m_in_frame = 0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_wdata = '0;
    logic [7:0]    q[$];
    int            m_cnt = 0;

    function automatic void model_byte(input logic [7:0] b);
        int n;
        logic [7:0] x;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1; q.delete();
                m_done = 0; m_err = 0; m_hold = 1;
            end
        end else begin
            q.push_back(b);
            n = q.size();
            if (n == 2) begin
                m_cnt = int'(q[0]) + 256 * int'(q[1]);
                if (m_cnt > (1 << AW)) begin
                    m_in_frame = 0; m_err = 1; m_hold = 1;
                end
            end else if (n >= 3 && n <= 2 + 4 * m_cnt) begin
                if ((n - 2) % 4 == 0) begin
                    m_we    = 1;
                    m_addr  = AW'((n - 2) / 4 - 1);
                    m_wdata = {q[n-1], q[n-2], q[n-3], q[n-4]};
                end
            end else if (n == 3 + 4 * m_cnt) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x ^= q[i];
                if (q[n-1] == x) begin m_done = 1; m_hold = 0; end
                else             begin m_err = 1; end
                m_in_frame = 0;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_we = 0; m_hold = 1; m_done = 0; m_err = 0;
            m_in_frame = 0; m_addr = '0; m_wdata = '0;
        end else begin
            m_we = 0;
            if (in_valid && m_ready) model_byte(in_data);
            m_ready = 1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready",   {31'd0, o_in_ready},  {31'd0, m_ready});
        chk("imem_we",    {31'd0, o_imem_we},   {31'd0, m_we});
        chk("imem_addr",  32'(o_imem_addr),     32'(m_addr));
        chk("imem_wdata", o_imem_wdata,         m_wdata);
        chk("core_hold",  {31'd0, o_core_hold}, {31'd0, m_hold});
        chk("done",       {31'd0, o_done},      {31'd0, m_done});
        chk("err",        {31'd0, o_err},       {31'd0, m_err});
        if (o_imem_we === 1'b1) begin
            wr_cnt++;
            tb_mem[o_imem_addr] = o_imem_wdata;
        end
    end

    // All stimulus tasks start and end on a negedge.
    task automatic send_b(input logic [7:0] b, input int gmax);
        repeat ($urandom_range(gmax, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom_range(255, 0);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gmax);
        foreach (f[i]) send_b(f[i], gmax);
        repeat (2) @(negedge clk);
    endtask

    task automatic build(input int cnt, input bit good, output logic [7:0] f[$]);
        logic [7:0] x, d;
        f.delete();
        f.push_back(8'hA5);
        f.push_back(cnt[7:0]);
        f.push_back(cnt[15:8]);
        x = cnt[7:0] ^ cnt[15:8];
        for (int i = 0; i < 4 * cnt; i++) begin
            d = $urandom_range(255, 0);
            f.push_back(d);
            x ^= d;
        end
        f.push_back(good ? x : (x ^ 8'h01));
    endtask

    task automatic clr_mem();
        for (int i = 0; i < (1 << AW); i++) tb_mem[i] = 32'hDEAD_BEEF;
        wr_cnt = 0;
    endtask

    logic [7:0] f2[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                          8'h93, 8'h05, 8'h10, 8'h00, 8'h92};
    logic [7:0] fr[$];

    task automatic check_case2(input string tag);
        chk({tag, "_writes"}, 32'(wr_cnt), 32'd2);
        chk({tag, "_word0"},  tb_mem[0], 32'h0000_0513);
        chk({tag, "_word1"},  tb_mem[1], 32'h0010_0593);
        chk({tag, "_done"},   {31'd0, o_done},      32'd1);
        chk({tag, "_hold"},   {31'd0, o_core_hold}, 32'd0);
        chk({tag, "_err"},    {31'd0, o_err},       32'd0);
    endtask

    initial begin
        int cnt;
        bit good;
        clr_mem();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, o_in_ready},  32'd0);
        chk("rst_we",    {31'd0, o_imem_we},   32'd0);
        chk("rst_addr",  32'(o_imem_addr),     32'd0);
        chk("rst_wdata", o_imem_wdata,         32'd0);
        chk("rst_hold",  {31'd0, o_core_hold}, 32'd1);
        chk("rst_done",  {31'd0, o_done},      32'd0);
        chk("rst_err",   {31'd0, o_err},       32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, o_in_ready}, 32'd1);

        // Two-word program with a good checksum.
        clr_mem();
        send_frame(f2, 0);
        check_case2("c2");

        // Same frame, bad checksum: words stay written, core stays held.
        clr_mem();
        f2[11] = 8'h93;
        send_frame(f2, 0);
        f2[11] = 8'h92;
        chk("c3_writes", 32'(wr_cnt), 32'd2);
        chk("c3_word0",  tb_mem[0], 32'h0000_0513);
        chk("c3_word1",  tb_mem[1], 32'h0010_0593);
        chk("c3_err",    {31'd0, o_err},       32'd1);
        chk("c3_hold",   {31'd0, o_core_hold}, 32'd1);
        chk("c3_done",   {31'd0, o_done},      32'd0);

        // Count over capacity, then an empty frame.
        clr_mem();
        send_frame('{8'hA5, 8'h41, 8'h00}, 0);
        chk("c4_err",    {31'd0, o_err},  32'd1);
        chk("c4_writes", 32'(wr_cnt),     32'd0);
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
        chk("c4_done",   {31'd0, o_done}, 32'd1);
        chk("c4_hold",   {31'd0, o_core_hold}, 32'd0);
        chk("c4_writes0", 32'(wr_cnt),    32'd0);

        // Reset mid-word discards the partial word.
        clr_mem();
        send_frame('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC}, 0);
        chk("c5_prewrites", 32'(wr_cnt), 32'd0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        // Checksum of 01 00 11 22 33 44 is 0x45.
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 0);
        chk("c5_writes", 32'(wr_cnt), 32'd1);
        chk("c5_word0",  tb_mem[0], 32'h4433_2211);
        chk("c5_done",   {31'd0, o_done}, 32'd1);

        // Case-2 frame with idle gaps between bytes.
        clr_mem();
        send_frame(f2, 4);
        check_case2("c6");

        // Full capacity fills every address exactly once; one more is rejected.
        clr_mem();
        build(1 << AW, 1, fr);
        send_frame(fr, 0);
        chk("full_writes", 32'(wr_cnt), 32'(1 << AW));
        chk("full_last",   tb_mem[(1<<AW)-1], {fr[4*(1<<AW)+2], fr[4*(1<<AW)+1], fr[4*(1<<AW)], fr[4*(1<<AW)-1]});
        chk("full_done",   {31'd0, o_done}, 32'd1);
        clr_mem();
        build((1 << AW) + 1, 1, fr);
        send_frame(fr, 0);
        chk("over_writes", 32'(wr_cnt), 32'd0);
        chk("over_err",    {31'd0, o_err}, 32'd1);

        // Random frames, junk between frames, random gaps.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(2, 0)) begin
                logic [7:0] j;
                j = $urandom_range(255, 0);
                if (j == 8'hA5) j = 8'h5A;
                send_b(j, 1);
            end
            cnt  = ($urandom_range(9, 0) == 0) ? (1 << AW) : $urandom_range(5, 0);
            good = ($urandom_range(3, 0) != 0);
            build(cnt, good, fr);
            send_frame(fr, $urandom_range(2, 0));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
